// File: rtl/audio_pkg.sv
// audio_pkg: shared state encoding, sample width and default sizing for the playback sequencer
package audio_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    PLAY  = 2'd2
  } state_t;
  localparam int SAMPLE_W = 32;
  localparam int DEF_FIFO_DEPTH = 16;
  localparam int DEF_REQ_LEVEL = 8;
  localparam int DEF_BURST_LEN = 8;
  localparam int DEF_UNDERRUN_LIMIT = 4;
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous sample buffer with flush; rd_data updates the cycle after a pop
module sample_fifo import audio_pkg::*; #(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [SAMPLE_W-1:0]     wr_data,
  output logic [SAMPLE_W-1:0]     rd_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  fill
);
  localparam int AW = $clog2(DEPTH);
  logic [SAMPLE_W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic wr, rd;
  assign full = fill == (AW+1)'(DEPTH);
  assign empty = fill == '0;
  assign rd = pop && !empty;
  // a full buffer still accepts a sample when a pop frees a slot in the same cycle
  assign wr = push && (!full || rd);
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= wr_data;
  end
  always_ff @(posedge clk) begin
    if (reset) rd_data <= '0;
    else if (rd && !flush) rd_data <= mem[rptr];
    if (reset || flush) begin
      wptr <= '0;
      rptr <= '0;
      fill <= '0;
    end else begin
      wptr <= wptr + AW'(wr);
      rptr <= rptr + AW'(rd);
      fill <= fill + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
endmodule

// File: rtl/audio_sched.sv
// audio_sched: sound-out playback sequencer (prime, burst requests, 44.1/22.05 kHz release).
// AUDIO_UNDERRUN_COUNT_EN enables the saturating underrun_count; otherwise it is tied to 0.
module audio_sched import audio_pkg::*; #(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int REQ_LEVEL = DEF_REQ_LEVEL,
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int UNDERRUN_LIMIT = DEF_UNDERRUN_LIMIT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                audio_starts,
  input  logic                audio_22khz,
  input  logic                all_1_packet,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_tick,
  output logic                data_req,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_out_valid,
  output logic                playing,
  output logic                underrun,
  output logic                overflow,
  output logic [15:0]         underrun_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = $clog2(BURST_LEN + 1);
  localparam int EW = $clog2(UNDERRUN_LIMIT + 1);
  state_t state;
  logic mode22, phase, out_zero;
  logic [OW-1:0] outstanding;
  logic [EW-1:0] empty_cnt;
  logic full, empty;
  logic [AW:0] fill;
  logic [SAMPLE_W-1:0] rd_data;
  logic ctl, active, need_pop, pop, quit, push, flush;
  always_comb begin
    ctl = all_1_packet || audio_starts;
    active = state != IDLE;
    need_pop = state == PLAY && sample_tick && !(mode22 && phase) && !ctl;
    pop = need_pop && !empty;
    quit = need_pop && empty && empty_cnt == EW'(UNDERRUN_LIMIT - 1);
    push = active && sample_valid && !ctl && !quit;
    flush = ctl || quit;
  end
  sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .flush(flush),
    .wr_data(sample_in),
    .rd_data(rd_data),
    .full(full),
    .empty(empty),
    .fill(fill)
  );
  // sample_out is the last popped word unless the last tick produced silence
  assign sample_out = out_zero ? '0 : rd_data;
  assign playing = state != IDLE;
  always_ff @(posedge clk) begin
    data_req <= 1'b0;
    sample_out_valid <= 1'b0;
    underrun <= 1'b0;
    overflow <= 1'b0;
    if (reset) begin
      state <= IDLE;
      mode22 <= 1'b0;
      phase <= 1'b0;
      out_zero <= 1'b0;
      outstanding <= '0;
      empty_cnt <= '0;
    end else if (all_1_packet) begin
      state <= IDLE;
      outstanding <= '0;
    end else if (audio_starts) begin
      state <= PRIME;
      mode22 <= audio_22khz;
      outstanding <= '0;
    end else begin
      overflow <= push && full && !pop;
      if (active && outstanding == '0 && fill <= (AW+1)'(REQ_LEVEL)) begin
        data_req <= 1'b1;
        outstanding <= OW'(BURST_LEN);
      end else if (push && outstanding != '0) outstanding <= outstanding - OW'(1);
      if (sample_tick) begin
        sample_out_valid <= 1'b1;
        if (state != PLAY) out_zero <= 1'b1;
        else begin
          phase <= !phase;
          if (need_pop) begin
            out_zero <= empty;
            underrun <= empty;
            empty_cnt <= empty ? empty_cnt + EW'(1) : '0;
            if (quit) state <= IDLE;
          end
        end
      end
      if (state == PRIME && fill >= (AW+1)'(REQ_LEVEL)) begin
        state <= PLAY;
        phase <= 1'b0;
        empty_cnt <= '0;
      end
    end
  end
`ifdef AUDIO_UNDERRUN_COUNT_EN
  logic [15:0] ucnt;
  always_ff @(posedge clk) begin
    if (reset) ucnt <= '0;
    else if (underrun && ucnt != 16'hFFFF) ucnt <= ucnt + 16'd1;
  end
  assign underrun_count = ucnt;
`else
  assign underrun_count = '0;
`endif
endmodule
